pattern_scheduler: RTL

- Synthesizable timed-stimulus player. Accepts timestamped stimulus records {time, bin, dec, hex} over a valid/ready stream, typically from a record FIFO loaded by the host.
- Holds each record until a free-running absolute timebase equals its timestamp, then drives the values onto registered outputs with a one-cycle strobe.
- Sits between the pattern record source and the DUT stimulus pins. Out-of-order (late) records are flagged and discarded, never applied.

---
 rtl/pattern_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pattern_scheduler.sv
`default_nettype none
// ============================================================================
// pattern_scheduler : holds timestamped stimulus records until the tick
// timebase reaches their time, then drives them onto registered outputs.
// Revision 1.0
// ============================================================================
module pattern_scheduler #(
  parameter int TS_W     = 32,
  parameter int BIN_W    = 4,
  parameter int DEC_W    = 32,
  parameter int HEX_W    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TS_W-1:0]  in_time,
  input  logic [BIN_W-1:0] in_bin,
  input  logic [DEC_W-1:0] in_dec,
  input  logic [HEX_W-1:0] in_hex,
  input  logic             in_last,
  output logic [BIN_W-1:0] out_bin,
  output logic [DEC_W-1:0] out_dec,
  output logic [HEX_W-1:0] out_hex,
  output logic             out_strobe,
  output logic [TS_W-1:0]  now,
  output logic             busy,
  output logic             done,
  output logic             late_err,
  output logic [15:0]      late_count
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [15:0]     CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [TS_W-1:0]    now_q, now_d;

  logic [TS_W-1:0]    rec_time_q, rec_time_d;
  logic [BIN_W-1:0]   rec_bin_q, rec_bin_d;
  logic [DEC_W-1:0]   rec_dec_q, rec_dec_d;
  logic [HEX_W-1:0]   rec_hex_q, rec_hex_d;
  logic               rec_last_q, rec_last_d;

  logic [BIN_W-1:0]   out_bin_q, out_bin_d;
  logic [DEC_W-1:0]   out_dec_q, out_dec_d;
  logic [HEX_W-1:0]   out_hex_q, out_hex_d;
  logic               strobe_q, strobe_d;
  logic               done_q, done_d;
  logic               late_err_q, late_err_d;
  logic [15:0]        late_count_q, late_count_d;

  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    now_d        = now_q;
    rec_time_d   = rec_time_q;
    rec_bin_d    = rec_bin_q;
    rec_dec_d    = rec_dec_q;
    rec_hex_d    = rec_hex_q;
    rec_last_d   = rec_last_q;
    out_bin_d    = out_bin_q;
    out_dec_d    = out_dec_q;
    out_hex_d    = out_hex_q;
    strobe_d     = 1'b0;
    done_d       = 1'b0;
    late_err_d   = late_err_q;
    late_count_d = late_count_q;

    // Timebase runs in every non-idle state, including the edge that leaves it.
    if (state_q != ST_IDLE) begin
      if (presc_q == PS_LAST) begin
        presc_d = '0;
        if (now_q != {TS_W{1'b1}}) begin
          now_d = now_q + TS_W'(1);
        end
      end else begin
        presc_d = presc_q + PS_W'(1);
      end
    end

    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d      = ST_FETCH;
            now_d        = '0;
            presc_d      = '0;
            late_err_d   = 1'b0;
            late_count_d = '0;
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            rec_time_d = in_time;
            rec_bin_d  = in_bin;
            rec_dec_d  = in_dec;
            rec_hex_d  = in_hex;
            rec_last_d = in_last;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (rec_time_q < now_q) begin
            late_err_d = 1'b1;
            if (late_count_q != CNT_MAX) begin
              late_count_d = late_count_q + 16'd1;
            end
            state_d = rec_last_q ? ST_IDLE : ST_FETCH;
            done_d  = rec_last_q;
          end else if (rec_time_q == now_q) begin
            out_bin_d = rec_bin_q;
            out_dec_d = rec_dec_q;
            out_hex_d = rec_hex_q;
            strobe_d  = 1'b1;
            state_d   = rec_last_q ? ST_IDLE : ST_FETCH;
            done_d    = rec_last_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      now_q        <= '0;
      rec_time_q   <= '0;
      rec_bin_q    <= '0;
      rec_dec_q    <= '0;
      rec_hex_q    <= '0;
      rec_last_q   <= 1'b0;
      out_bin_q    <= '0;
      out_dec_q    <= '0;
      out_hex_q    <= '0;
      strobe_q     <= 1'b0;
      done_q       <= 1'b0;
      late_err_q   <= 1'b0;
      late_count_q <= '0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      now_q        <= now_d;
      rec_time_q   <= rec_time_d;
      rec_bin_q    <= rec_bin_d;
      rec_dec_q    <= rec_dec_d;
      rec_hex_q    <= rec_hex_d;
      rec_last_q   <= rec_last_d;
      out_bin_q    <= out_bin_d;
      out_dec_q    <= out_dec_d;
      out_hex_q    <= out_hex_d;
      strobe_q     <= strobe_d;
      done_q       <= done_d;
      late_err_q   <= late_err_d;
      late_count_q <= late_count_d;
    end
  end

  assign in_ready   = (state_q == ST_FETCH);
  assign busy       = (state_q != ST_IDLE);
  assign now        = now_q;
  assign out_bin    = out_bin_q;
  assign out_dec    = out_dec_q;
  assign out_hex    = out_hex_q;
  assign out_strobe = strobe_q;
  assign done       = done_q;
  assign late_err   = late_err_q;
  assign late_count = late_count_q;

endmodule
`default_nettype wire
